// File: rtl/lv_fault_intb_ctrl.sv
// Low-voltage fault collector: synchronizes raw fault flags into sticky W1C STATUS1/STATUS2
// values and drives the active-low INTB pin in level or fixed-width pulse mode.
module lv_fault_intb_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int PW_SHORT    = 16,
  parameter int PW_MID      = 64,
  parameter int PW_LONG     = 256,
  parameter int GAP_CYC     = 8,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] st1_flt_i,
  input  logic [7:0] st2_flt_i,
  input  logic [7:0] mask1_i,
  input  logic [7:0] mask2_i,
  input  logic [7:0] st1_clr_i,
  input  logic [7:0] st2_clr_i,
  input  logic [1:0] intb_cfg_i,
  input  logic       mode_reset_i,
  output logic [7:0] status1_o,
  output logic [7:0] status2_o,
  output logic       int_pend_o,
  output logic       intb_o
);

  // STATUS1 bit6 is reserved and never latches.
  localparam logic [7:0] ST1_VALID = 8'hBF;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

  logic [SYNC_STAGES-1:0][7:0] s1_sync_q, s2_sync_q;
  logic [7:0]       st1_q, st1_d, st2_q, st2_d;
  logic [15:0]      mv, mv_q;
  logic             new_evt, start;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retrig_q, retrig_d;
  logic             intb_q, intb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sync_q <= '0;
      s2_sync_q <= '0;
    end else begin
      s1_sync_q[0] <= st1_flt_i;
      s2_sync_q[0] <= st2_flt_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        s1_sync_q[i] <= s1_sync_q[i-1];
        s2_sync_q[i] <= s2_sync_q[i-1];
      end
    end
  end

  // Set wins over clear in the same cycle; mode reset wins over everything.
  always_comb begin
    st1_d = ((st1_q & ~st1_clr_i) | s1_sync_q[SYNC_STAGES-1]) & ST1_VALID;
    st2_d = (st2_q & ~st2_clr_i) | s2_sync_q[SYNC_STAGES-1];
    if (mode_reset_i) begin
      st1_d = '0;
      st2_d = '0;
    end
  end

  // Edge detect on the masked vector so an unmask of a set bit is a new event.
  assign mv         = {st2_q & ~mask2_i, st1_q & ~mask1_i & ST1_VALID};
  assign new_evt    = |(mv & ~mv_q);
  assign int_pend_o = |mv;
  assign start      = (new_evt | retrig_q) && (intb_cfg_i != 2'b00);

  function automatic logic [CNT_W-1:0] width_m1(input logic [1:0] cfg);
    case (cfg)
      2'b01:   width_m1 = CNT_W'(PW_SHORT - 1);
      2'b10:   width_m1 = CNT_W'(PW_MID - 1);
      default: width_m1 = CNT_W'(PW_LONG - 1);
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retrig_d = retrig_q;
    intb_d   = 1'b1;
    case (state_q)
      IDLE: begin
        if (intb_cfg_i == 2'b00) begin
          intb_d   = ~int_pend_o;
          retrig_d = 1'b0;
        end else if (start) begin
          state_d  = PULSE;
          cnt_d    = width_m1(intb_cfg_i);
          retrig_d = 1'b0;
          intb_d   = 1'b0;
        end
      end
      PULSE: begin
        retrig_d = retrig_q | new_evt;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYC - 1);
        end else begin
          cnt_d  = cnt_q - 1'b1;
          intb_d = 1'b0;
        end
      end
      GAP: begin
        retrig_d = retrig_q | new_evt;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (start) begin
          // Pending retrigger fires right at gap end so the high time is exactly GAP_CYC.
          state_d  = PULSE;
          cnt_d    = width_m1(intb_cfg_i);
          retrig_d = 1'b0;
          intb_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (mode_reset_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      retrig_d = 1'b0;
      intb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_q    <= '0;
      st2_q    <= '0;
      mv_q     <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      retrig_q <= 1'b0;
      intb_q   <= 1'b1;
    end else begin
      st1_q    <= st1_d;
      st2_q    <= st2_d;
      mv_q     <= mode_reset_i ? '0 : mv;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retrig_q <= retrig_d;
      intb_q   <= intb_d;
    end
  end

  assign status1_o = st1_q;
  assign status2_o = st2_q;
  assign intb_o    = intb_q;

endmodule

// File: doc/lv_fault_intb_ctrl.md
Name: lv_fault_intb_ctrl

Overview:
- Low-voltage-side fault collector; sits directly upstream of the register bank.
- Synchronizes raw fault flags and latches them into sticky STATUS1/STATUS2 values (write-1-to-clear), which it feeds to the register bank.
- Applies MASK1/MASK2 and drives the active-low INTB pin in level or pulse mode, selected by the WDGINTB_CONFIG field of COM_CONFIG1.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every fault input
- PW_SHORT, 16, INTB pulse width in clocks for cfg 2'b01
- PW_MID, 64, INTB pulse width in clocks for cfg 2'b10
- PW_LONG, 256, INTB pulse width in clocks for cfg 2'b11
- GAP_CYC, 8, minimum INTB high time between pulses, in clocks
- CNT_W, 9, pulse/gap counter width; must hold max(PW_LONG, GAP_CYC)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- st1_flt_i  input  8  raw STATUS1 fault levels (bit order = STATUS1 layout, bit6 reserved)
- st2_flt_i  input  8  raw STATUS2 fault levels (STATUS2 layout)
- mask1_i  input  8  MASK1 register value, 1 = masked
- mask2_i  input  8  MASK2 register value
- st1_clr_i  input  8  one-cycle write-1-to-clear strobe for STATUS1
- st2_clr_i  input  8  one-cycle write-1-to-clear strobe for STATUS2
- intb_cfg_i  input  2  WDGINTB_CONFIG: 00 level, 01/10/11 pulse PW_SHORT/PW_MID/PW_LONG
- mode_reset_i  input  1  MODE.reset_en; synchronous clear of the whole block
- status1_o  output  8  sticky STATUS1 value
- status2_o  output  8  sticky STATUS2 value
- int_pend_o  output  1  any unmasked sticky bit set
- intb_o  output  1  active-low interrupt pin drive

Behaviour:
- Reset values (rst_n low): status1_o = 0, status2_o = 0, int_pend_o = 0, intb_o = 1, sync flops = 0, FSM = IDLE, counter = 0, retrig flag = 0.
- Synchronizer: each fault input passes through SYNC_STAGES flops.
- Sticky bits:
  - A bit sets on any cycle its synchronized level is 1.
  - It clears only on the matching clr strobe bit.
  - Set and clear in the same cycle: the bit stays 1.
  - Status bits are visible SYNC_STAGES+1 clocks after the raw input rises.
- STATUS1 bit6 (reserved): always 0; its input, mask and clear bits are ignored.
- Masks: gate interrupt generation only. Masked bits still latch and read back.
- int_pend_o = OR over (status & ~mask) of both registers, combinational from the sticky registers.
- new_evt: any unmasked sticky bit going 0->1 this cycle, from a registered compare of the previous value.
- An unmask of an already-set bit counts as new_evt: it is evaluated on the masked-status vector.
- Level mode (cfg 00):
  - intb_o = ~int_pend_o, registered, so it lags int_pend_o by 1 clock.
  - The FSM stays in IDLE.
- Pulse mode (cfg != 00), FSM states IDLE, PULSE, GAP:
  - IDLE: intb_o = 1. On new_evt or retrig flag set: latch the width from cfg, load the counter, clear retrig, go to PULSE.
  - PULSE: intb_o = 0 for exactly the latched width in clocks, then go to GAP.
  - GAP: intb_o = 1 for exactly GAP_CYC clocks, then go to IDLE.
  - new_evt during PULSE or GAP sets retrig. Multiple events collapse into one extra pulse.
  - intb_o falls 1 clock after the sticky bit sets, so the whole path is SYNC_STAGES+2 clocks from the raw input.
- Config change:
  - cfg is sampled only in IDLE; a change during PULSE or GAP affects the next pulse.
  - Switching from pulse to level mode while in PULSE or GAP: the current pulse and gap complete, then level mode applies.
- mode_reset_i high: synchronous clear of sticky bits, retrig flag and counter; FSM to IDLE; intb_o = 1 from the next clock. Sync flops keep running. This overrides sets in the same cycle.
- Reset mid-pulse (rst_n low): intb_o returns to 1 immediately (asynchronous).

Test Plan:
- Reset, then pulse st1_flt_i[1] (crc_err) high for 1 clock with mask1 = 0, cfg = 00 -> status1_o = 8'h02 at clock 3; int_pend_o = 1; intb_o = 0 at clock 4; st1_clr_i = 8'h02 -> intb_o = 1 two clocks later.
- st2_flt_i[7] held high, mask2_i = 8'h80 -> status2_o = 8'h80, int_pend_o = 0, intb_o stays 1; then mask2_i = 0 -> int_pend_o = 1 and intb_o = 0.
- cfg = 01, single event on st1_flt_i[3] -> intb_o low for exactly 16 clocks then high; a second event during the pulse -> second 16-clock pulse starting exactly 8 clocks after the first ends.
- Fault level held at 1 while st1_clr_i strobes the same bit -> bit remains 1; st1_flt_i[6] asserted -> status1_o[6] = 0.
- cfg = 11 pulse in progress, change cfg to 01 at clock 100 of the pulse -> current pulse lasts 256 clocks; next event gives a 16-clock pulse.
- mode_reset_i asserted mid-pulse with status1_o = 8'h21 -> next clock status = 0, intb_o = 1, FSM IDLE; rst_n low mid-pulse -> intb_o = 1 asynchronously.
